// File: rtl/nor_reader_if.sv
// Request/response port of the NOR flash read engine.
// master = fetch logic issuing reads, slave = the read engine.
interface nor_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [1:0]  req_len;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req_valid, req_addr, req_len,
                  input  req_ready, rvalid, rdata);
  modport slave  (input  req_valid, req_addr, req_len,
                  output req_ready, rvalid, rdata);
endinterface

// File: rtl/nor_reader.sv
// Single-transaction read engine for an external serial NOR flash.
// Runs command, 24-bit address, optional dummy clocks and 1-4 data bytes,
// returning the bytes little-endian in rdata. SCK is clk/2, mode 0.
module nor_reader #(
  parameter string      NOR_TYPE = "spi",
  parameter logic [7:0] CMD      = 8'h03,
  parameter int         DUMMY    = 10
) (
  input  logic       clk,
  input  logic       rst,
  nor_reader_if.slave bus,
  output logic       sck,
  output logic       csb,
  output logic [3:0] sio_o,
  output logic [3:0] sio_oe,
  input  logic [3:0] sio_i
);

  localparam bit         QSPI      = (NOR_TYPE == "qspi");
  // SCK periods per phase; qspi moves a nibble per period
  localparam logic [7:0] CMD_P     = QSPI ? 8'd2 : 8'd8;
  localparam logic [7:0] ADDR_P    = QSPI ? 8'd6 : 8'd24;
  localparam logic [7:0] BYTE_P    = QSPI ? 8'd2 : 8'd8;
  localparam logic [7:0] DUMMY_P   = 8'(DUMMY);
  localparam bit         HAS_DUMMY = QSPI && (DUMMY > 0);
  localparam logic [3:0] DRV_OE    = QSPI ? 4'hF : 4'h1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

  state_t      state;
  logic        ph;     // 0: next edge starts a low half, 1: next edge raises SCK
  logic [7:0]  cnt;    // periods left in the current phase / byte, minus 1
  logic [31:0] sh;     // {CMD, addr} shifted out MSB first
  logic [1:0]  len;
  logic [1:0]  k;      // byte index being received
  logic        last;   // final data bit sampled; next low half winds down
  logic [7:0]  bsh;    // partial byte
  logic [31:0] rin;    // bytes gathered so far
  logic [7:0]  nb;

  // byte shifter with the incoming bit(s) appended
  always_comb begin
    nb = QSPI ? {bsh[3:0], sio_i} : {bsh[6:0], sio_i[1]};
  end

  // Whole transaction FSM; every pin and handshake output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ph            <= 1'b0;
      cnt           <= '0;
      sh            <= '0;
      len           <= '0;
      k             <= '0;
      last          <= 1'b0;
      bsh           <= '0;
      rin           <= '0;
      sck           <= 1'b0;
      csb           <= 1'b1;
      sio_o         <= '0;
      sio_oe        <= '0;
      bus.req_ready <= 1'b1;
      bus.rvalid    <= 1'b0;
      bus.rdata     <= '0;
    end else begin
      bus.rvalid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) begin
            csb        <= 1'b1;
            bus.rvalid <= 1'b1;
            bus.rdata  <= rin;
            state      <= S_IDLE;
          end
          if (bus.req_valid && bus.req_ready) begin
            state         <= S_CMD;
            ph            <= 1'b0;
            cnt           <= CMD_P - 8'd1;
            sh            <= {CMD, bus.req_addr};
            len           <= bus.req_len;
            k             <= '0;
            last          <= 1'b0;
            rin           <= '0;
            bus.req_ready <= 1'b0;
            // a back-to-back accept in DONE must not clobber the result being returned
            if (state == S_IDLE) bus.rdata <= '0;
          end
        end
        default: begin
          if (!ph) begin
            sck <= 1'b0;
            csb <= 1'b0;
            ph  <= 1'b1;
            if (last) begin
              state         <= S_DONE;
              bus.req_ready <= 1'b1;
            end else if (state == S_CMD || state == S_ADDR) begin
              sio_o  <= QSPI ? sh[31:28] : {3'b000, sh[31]};
              sio_oe <= DRV_OE;
              sh     <= QSPI ? {sh[27:0], 4'h0} : {sh[30:0], 1'b0};
            end else begin
              sio_o  <= '0;
              sio_oe <= '0;
            end
          end else begin
            sck <= 1'b1;
            ph  <= 1'b0;
            if (state == S_DATA) begin
              bsh <= nb;
              if (cnt == 8'd0) begin
                rin[8*k +: 8] <= nb;
                cnt           <= BYTE_P - 8'd1;
                if (k == len) last <= 1'b1;
                else          k    <= k + 2'd1;
              end else begin
                cnt <= cnt - 8'd1;
              end
            end else if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end else if (state == S_CMD) begin
              state <= S_ADDR;
              cnt   <= ADDR_P - 8'd1;
            end else if (state == S_ADDR && HAS_DUMMY) begin
              state <= S_DUMMY;
              cnt   <= DUMMY_P - 8'd1;
            end else begin
              state <= S_DATA;
              cnt   <= BYTE_P - 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_reader.sv
// Directed bench: one spi and one qspi engine, each attached to a small
// behavioural flash that decodes the address it is sent and streams bytes back.
module tb_nor_reader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nor_reader_if ifs0 ();
  nor_reader_if ifs1 ();

  logic [1:0]       rv;
  logic [1:0][23:0] ra;
  logic [1:0][1:0]  rl;
  logic [1:0]       rdy, rvl;
  logic [1:0][31:0] rd;
  logic [1:0]       sck_w, csb_w;
  logic [1:0][3:0]  so_w, oe_w;
  logic [1:0][3:0]  si_r = '0;

  assign ifs0.req_valid = rv[0];
  assign ifs0.req_addr  = ra[0];
  assign ifs0.req_len   = rl[0];
  assign ifs1.req_valid = rv[1];
  assign ifs1.req_addr  = ra[1];
  assign ifs1.req_len   = rl[1];
  assign rdy = {ifs1.req_ready, ifs0.req_ready};
  assign rvl = {ifs1.rvalid, ifs0.rvalid};
  assign rd  = {ifs1.rdata, ifs0.rdata};

  nor_reader #(.NOR_TYPE("spi"), .CMD(8'h03), .DUMMY(10)) u_spi (
    .clk(clk), .rst(rst), .bus(ifs0), .sck(sck_w[0]), .csb(csb_w[0]),
    .sio_o(so_w[0]), .sio_oe(oe_w[0]), .sio_i(si_r[0]));

  nor_reader #(.NOR_TYPE("qspi"), .CMD(8'hEB), .DUMMY(10)) u_qspi (
    .clk(clk), .rst(rst), .bus(ifs1), .sck(sck_w[1]), .csb(csb_w[1]),
    .sio_o(so_w[1]), .sio_oe(oe_w[1]), .sio_i(si_r[1]));

  // ---------------- flash model ----------------
  logic [7:0]  mem [256];
  int          rise [2];
  logic [31:0] cap [2];
  logic [1:0]  sck_q = '0;

  // data nibble/bit j of the stream starting at address a
  function automatic logic [3:0] fdata(input int i, input int j, input logic [23:0] a);
    logic [7:0] b;
    logic       bt;
    if (i == 0) begin
      b  = mem[8'(a + 24'(j / 8))];
      bt = b[7 - (j % 8)];
      return {~bt, ~bt, bt, ~bt};   // only bit 1 is meaningful in spi
    end
    b = mem[8'(a + 24'(j / 2))];
    return (j % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  // flash samples on SCK rise, shifts out on SCK fall (mode 0)
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (csb_w[i]) begin
        rise[i] <= 0;
      end else if (sck_w[i] && !sck_q[i]) begin
        rise[i] <= rise[i] + 1;
        if (i == 0 && rise[i] < 32) cap[i] <= {cap[i][30:0], so_w[i][0]};
        if (i == 1 && rise[i] < 8)  cap[i] <= {cap[i][27:0], so_w[i]};
      end else if (!sck_w[i] && sck_q[i]) begin
        if (i == 0 && rise[i] >= 32) si_r[i] <= fdata(0, rise[i] - 32, cap[i][23:0]);
        if (i == 1 && rise[i] >= 18) si_r[i] <= fdata(1, rise[i] - 18, cap[i][23:0]);
      end
      sck_q[i] <= sck_w[i];
    end
  end

  // ---------------- checking ----------------
  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  int          lat, oe_drop, oe1, rdy_edge;
  bit          oe_bad;
  logic [31:0] dat;

  // count edges from the last accept until rvalid, watching the pins on the way
  task automatic wait_done(input int i);
    lat = -1; oe_drop = -1; oe1 = -1; rdy_edge = -1; oe_bad = 0; dat = '0;
    for (int e = 1; e <= 400 && lat < 0; e++) begin
      @(posedge clk); #1;
      if (e == 1) oe1 = int'(oe_w[i]);
      if (!csb_w[i]) begin
        if (oe_drop < 0 && oe_w[i] == 4'h0) oe_drop = e;
        else if (oe_drop >= 0 && oe_w[i] != 4'h0) oe_bad = 1;
      end
      if (rdy_edge < 0 && rdy[i]) rdy_edge = e;
      if (rvl[i]) begin lat = e; dat = rd[i]; end
    end
  endtask

  task automatic issue(input int i, input logic [23:0] a, input logic [1:0] l,
                       input bit keep, input logic [23:0] a2, input logic [1:0] l2);
    @(negedge clk);
    rv[i] = 1'b1; ra[i] = a; rl[i] = l;
    @(posedge clk); #1;          // edge 0: accept
    if (keep) begin ra[i] = a2; rl[i] = l2; end
    else rv[i] = 1'b0;
    wait_done(i);
  endtask

  initial begin
    bit seen;
    rv = '0; ra = '0; rl = '0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a * 7 + 3);
    mem[8'h10] = 8'hA5;
    mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h23] = 8'h44;

    // reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_csb",    64'(csb_w), 64'h3);
    chk("rst_sck",    64'(sck_w), 64'h0);
    chk("rst_sio_oe", 64'(oe_w),  64'h0);
    chk("rst_sio_o",  64'(so_w),  64'h0);
    chk("rst_rvalid", 64'(rvl),   64'h0);
    chk("rst_rdata",  64'(rd),    64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",  64'(rdy),   64'h3);

    // spi, 1 byte: N = 40
    issue(0, 24'h000010, 2'd0, 0, 24'h0, 2'd0);
    chk("spi1_mosi",   64'(cap[0]),   64'h03000010);
    chk("spi1_oe_cmd", 64'(oe1),      64'h1);
    chk("spi1_oe_off", 64'(oe_drop),  64'd65);
    chk("spi1_oe_bad", 64'(oe_bad),   64'd0);
    chk("spi1_ready",  64'(rdy_edge), 64'd81);
    chk("spi1_lat",    64'(lat),      64'd82);
    chk("spi1_data",   64'(dat),      64'h000000A5);
    @(posedge clk); #1;
    chk("spi1_pulse",  64'(rvl[0]),   64'h0);
    chk("spi1_hold",   64'(rd[0]),    64'h000000A5);

    // spi, 4 bytes: N = 64
    issue(0, 24'h000020, 2'd3, 0, 24'h0, 2'd0);
    chk("spi4_lat",    64'(lat),      64'd130);
    chk("spi4_data",   64'(dat),      64'h44332211);

    // qspi, 4 bytes: N = 8+10+8 = 26
    issue(1, 24'h000020, 2'd3, 0, 24'h0, 2'd0);
    chk("qspi4_nib",    64'(cap[1]),  64'hEB000020);
    chk("qspi4_oe_cmd", 64'(oe1),     64'hF);
    chk("qspi4_oe_off", 64'(oe_drop), 64'd17);
    chk("qspi4_oe_bad", 64'(oe_bad),  64'd0);
    chk("qspi4_lat",    64'(lat),     64'd54);
    chk("qspi4_data",   64'(dat),     64'h44332211);

    // qspi, 2 bytes: N = 22
    issue(1, 24'h000020, 2'd1, 0, 24'h0, 2'd0);
    chk("qspi2_lat",   64'(lat),      64'd46);
    chk("qspi2_data",  64'(dat),      64'h00002211);

    // back-to-back with req_valid held: second accepted on the first's rvalid edge
    issue(0, 24'h000010, 2'd0, 1, 24'h000020, 2'd1);
    chk("b2b_ready1",  64'(rdy_edge), 64'd81);
    chk("b2b_lat1",    64'(lat),      64'd82);
    chk("b2b_data1",   64'(dat),      64'h000000A5);
    chk("b2b_taken",   64'(rdy[0]),   64'h0);
    chk("b2b_csb_hi",  64'(csb_w[0]), 64'h1);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("b2b_csb_lo",  64'(csb_w[0]), 64'h0);
    // second accept at 82, rvalid at 82 + 2*(32+16) + 2 = 180, i.e. 97 edges after 83
    wait_done(0);
    chk("b2b_lat2",    64'(lat),      64'd97);
    chk("b2b_data2",   64'(dat),      64'h00002211);

    // reset in the middle of a spi read
    @(negedge clk);
    rv[0] = 1'b1; ra[0] = 24'h000020; rl[0] = 2'd3;
    @(posedge clk); #1 rv[0] = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("mid_busy",    64'(csb_w[0]), 64'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_pins", 64'({csb_w[0], sck_w[0], oe_w[0]}), 64'({1'b1, 1'b0, 4'h0}));
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (rvl[0]) seen = 1; end
    @(negedge clk); rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (rvl[0]) seen = 1; end
    chk("mid_no_rvalid", 64'(seen),   64'h0);
    chk("mid_ready",     64'(rdy[0]), 64'h1);

    // fresh read after reset
    issue(0, 24'h000020, 2'd3, 0, 24'h0, 2'd0);
    chk("post_lat",    64'(lat),      64'd130);
    chk("post_data",   64'(dat),      64'h44332211);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
